// File: rtl/pcie_arb_pkg.sv
// Shared types and defaults for the PCIe endpoint TX channel arbiter.
package pcie_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRIVE = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  localparam int unsigned MAX_NUM_CHN   = 32'd16;
  localparam int unsigned DEF_START_TMO = 32'd16;
  localparam int unsigned DEF_GAP_CYC   = 32'd1;
  localparam int unsigned TMO_CNT_W     = 32'd8;
  localparam int unsigned GAP_CNT_W     = 32'd4;

  // Grant index width, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/pcie_chn_rr_arb_chk.sv
// Grant-vector invariants of the channel arbiter.
module pcie_chn_rr_arb_chk
  import pcie_arb_pkg::*;
#(
  parameter int unsigned NUM_CHN = 32'd2
) (
  input logic               clk,
  input logic               rst,
  input logic [NUM_CHN-1:0] chn_trn,
  input arb_state_t         state_q
);

  logic past_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      past_valid_q <= 1'b0;
    end else begin
      past_valid_q <= 1'b1;
    end
  end

  a_trn_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(chn_trn));

  a_trn_change: assert property (@(posedge clk) disable iff (rst)
    (past_valid_q && $changed(chn_trn)) |->
      (($past(state_q) == IDLE) && (state_q == GRANT)) ||
      (($past(state_q) inside {GRANT, DRIVE}) && (state_q != $past(state_q))));

endmodule

// File: rtl/rr_pick.sv
// Combinational circular priority encoder: first requester at or above rr_ptr.
module rr_pick
  import pcie_arb_pkg::*;
#(
  parameter int unsigned NUM_CHN = 32'd2,
  parameter int unsigned IDXW    = idx_width(NUM_CHN)
) (
  input  logic [NUM_CHN-1:0] req,
  input  logic [IDXW-1:0]    rr_ptr,
  output logic               valid,
  output logic [IDXW-1:0]    idx
);

  logic [2*NUM_CHN-1:0] dbl_req;
  logic [2*NUM_CHN-1:0] masked_req;

  assign dbl_req = {req, req};
  assign valid   = |req;

  // Lower copy is masked below rr_ptr; the upper copy supplies the wrap-around.
  always_comb begin
    masked_req = '0;
    for (int i = 0; i < int'(2 * NUM_CHN); i++) begin
      masked_req[i] = dbl_req[i] & ((i >= int'(NUM_CHN)) || (i >= int'(rr_ptr)));
    end
  end

  always_comb begin
    idx = '0;
    for (int i = int'(2 * NUM_CHN) - 1; i >= 0; i--) begin
      idx = masked_req[i] ? ((i >= int'(NUM_CHN)) ? IDXW'(i - int'(NUM_CHN)) : IDXW'(i)) : idx;
    end
  end

endmodule

// File: rtl/pcie_chn_rr_arb.sv
// Round-robin arbiter handing the single PCIe endpoint TX interface to one DMA channel
// at a time, with a start timeout and an inter-grant gap.
module pcie_chn_rr_arb
  import pcie_arb_pkg::*;
#(
  parameter int unsigned NUM_CHN   = 32'd2,
  parameter int unsigned IDXW      = idx_width(NUM_CHN),
  parameter int unsigned START_TMO = DEF_START_TMO,
  parameter int unsigned GAP_CYC   = DEF_GAP_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CHN-1:0] chn_reqep,
  input  logic [NUM_CHN-1:0] chn_drvn,
  output logic [NUM_CHN-1:0] chn_trn,
  output logic [IDXW-1:0]    chn_grant_idx,
  output logic               arb_busy,
  output logic               start_tmo
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST   = TMO_CNT_W'(START_TMO - 32'd1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST   = (GAP_CYC > 32'd0) ? GAP_CNT_W'(GAP_CYC - 32'd1) : '0;
  localparam logic [IDXW-1:0]      LAST_CHN   = IDXW'(NUM_CHN - 32'd1);
  localparam arb_state_t           EXIT_STATE = (GAP_CYC == 32'd0) ? IDLE : GAP;

  arb_state_t           state_q, state_d;
  logic [NUM_CHN-1:0]   trn_q, trn_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 busy_q, busy_d;
  logic                 tmo_q, tmo_d;
  logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;

  logic            pick_valid;
  logic [IDXW-1:0] pick_idx;
  logic            any_drvn;
  logic            own_drvn;

  assign any_drvn = |chn_drvn;
  // idx_q always names the owner while in GRANT/DRIVE.
  assign own_drvn = chn_drvn[idx_q];

  rr_pick #(
    .NUM_CHN (NUM_CHN),
    .IDXW    (IDXW)
  ) u_rr_pick (
    .req    (chn_reqep),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      trn_q     <= '0;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      busy_q    <= 1'b0;
      tmo_q     <= 1'b0;
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      trn_q     <= trn_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      busy_q    <= busy_d;
      tmo_q     <= tmo_d;
      tmo_cnt_q <= tmo_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_valid && !any_drvn) state_d = GRANT;
        else                         state_d = IDLE;
      end
      GRANT: begin
        if (own_drvn)                    state_d = DRIVE;
        else if (tmo_cnt_q == TMO_LAST) state_d = EXIT_STATE;
        else                             state_d = GRANT;
      end
      DRIVE: begin
        if (!own_drvn) state_d = EXIT_STATE;
        else           state_d = DRIVE;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       state_d = GAP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    trn_d     = trn_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    tmo_d     = 1'b0;
    tmo_cnt_d = tmo_cnt_q;
    gap_cnt_d = gap_cnt_q;
    busy_d    = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (state_d == GRANT) begin
          trn_d     = {{(NUM_CHN-1){1'b0}}, 1'b1} << pick_idx;
          idx_d     = pick_idx;
          rr_ptr_d  = (pick_idx == LAST_CHN) ? '0 : pick_idx + IDXW'(1);
          tmo_cnt_d = '0;
        end else begin
          trn_d = '0;
        end
      end
      GRANT: begin
        if (state_d == DRIVE) begin
          trn_d = trn_q;
        end else if (state_d == GRANT) begin
          tmo_cnt_d = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 8'd1;
        end else begin
          trn_d     = '0;
          tmo_d     = 1'b1;
          gap_cnt_d = '0;
        end
      end
      DRIVE: begin
        if (state_d != DRIVE) begin
          trn_d     = '0;
          gap_cnt_d = '0;
        end else begin
          trn_d = trn_q;
        end
      end
      GAP: begin
        trn_d     = '0;
        gap_cnt_d = (gap_cnt_q == GAP_LAST) ? gap_cnt_q : gap_cnt_q + 4'd1;
      end
      default: trn_d = '0;
    endcase
  end

  assign chn_trn       = trn_q;
  assign chn_grant_idx = idx_q;
  assign arb_busy      = busy_q;
  assign start_tmo     = tmo_q;

  pcie_chn_rr_arb_chk #(
    .NUM_CHN (NUM_CHN)
  ) u_chk (
    .clk     (clk),
    .rst     (rst),
    .chn_trn (trn_q),
    .state_q (state_q)
  );

endmodule
